// File: rtl/ide_cycle.sv
// ide_cycle
//
// Bus-cycle controller placed behind the gayle register block. It turns the
// 68030 strobes plus gayle's ACCESS decode into either a Gayle register cycle
// terminated with DSACK1_n, or a timed IDE PIO cycle in the $DA0000-$DA7FFF
// window (CS setup, IOR/IOW strobe stretched by IORDY, CS hold).
//
// Ports
//   CLKCPU        in   CPU clock, all state changes on the rising edge
//   RESET         in   asynchronous active-low reset
//   AS20          in   68030 address strobe, active-low, synchronous to CLKCPU
//   RW            in   1 = read, 0 = write
//   A[23:0]       in   CPU address
//   GAYLE_ACCESS  in   active-low Gayle register decode
//   IDE_IORDY     in   drive ready, 0 stretches the strobe
//   IDE_CS0_n     out  IDE chip select 0 (A[14] = 0)
//   IDE_CS1_n     out  IDE chip select 1 (A[14] = 1)
//   IDE_A[2:0]    out  IDE register address (A[4:2])
//   IDE_IOR_n     out  IDE read strobe
//   IDE_IOW_n     out  IDE write strobe
//   IDE_BUFOE_n   out  data buffer output enable
//   IDE_DIR       out  buffer direction, 1 = drive toward CPU
//   DSACK1_n      out  16-bit port termination to the CPU
//
// Every output is a register; the output process computes the value each
// register takes on the next edge.

module ide_cycle #(
   parameter int unsigned SETUP_CLKS    = 2,
   parameter int unsigned STROBE_CLKS   = 6,
   parameter int unsigned HOLD_CLKS     = 2,
   parameter int unsigned GAYLE_WAIT    = 1,
   parameter int unsigned IORDY_TIMEOUT = 255
) (
   input  logic        CLKCPU,
   input  logic        RESET,
   input  logic        AS20,
   input  logic        RW,
   input  logic [23:0] A,
   input  logic        GAYLE_ACCESS,
   input  logic        IDE_IORDY,
   output logic        IDE_CS0_n,
   output logic        IDE_CS1_n,
   output logic [2:0]  IDE_A,
   output logic        IDE_IOR_n,
   output logic        IDE_IOW_n,
   output logic        IDE_BUFOE_n,
   output logic        IDE_DIR,
   output logic        DSACK1_n
);

   // Counters are loaded with N-1 because the loading edge itself is the
   // first of the N cycles.
   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CLKS - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CLKS - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CLKS - 1);
   localparam logic [3:0] GAYLE_LD  = 4'(GAYLE_WAIT - 1);
   localparam logic [7:0] TMO_LD    = 8'(IORDY_TIMEOUT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_ACK,
      ST_HOLD,
      ST_GWAIT,
      ST_GACK
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic [7:0] tmo_q;
   logic [7:0] tmo_d;

   logic       cs0_d;
   logic       cs1_d;
   logic [2:0] ide_a_d;
   logic       ior_d;
   logic       iow_d;
   logic       bufoe_d;
   logic       dir_d;
   logic       dsack_d;

   logic       ide_hit;
   logic       gayle_hit;
   logic       start_ide;
   logic       start_gayle;
   logic       cnt_zero;
   logic       tmo_zero;
   logic       stretch;
   logic       unused_addr;

   // Saturating decrements: a counter parked at zero stays at zero.
   function automatic logic [3:0] dec_cnt(input logic [3:0] v);
      return (v == 4'd0) ? 4'd0 : v - 4'd1;
   endfunction

   function automatic logic [7:0] dec_tmo(input logic [7:0] v);
      return (v == 8'd0) ? 8'd0 : v - 8'd1;
   endfunction

   // IDE decode takes priority when gayle also claims the cycle.
   assign ide_hit     = (A[23:15] == {8'hDA, 1'b0});
   assign gayle_hit   = ~GAYLE_ACCESS & ~ide_hit;
   assign start_ide   = ~AS20 & ide_hit;
   assign start_gayle = ~AS20 & gayle_hit;
   assign cnt_zero    = (cnt_q == 4'd0);
   assign tmo_zero    = (tmo_q == 8'd0);
   // Minimum strobe width reached but the drive is not ready and the
   // timeout budget is not yet spent.
   assign stretch     = cnt_zero & ~IDE_IORDY & ~tmo_zero;
   assign unused_addr = ^{A[13:5], A[1:0]};

   // ---- state register ----
   always_ff @(posedge CLKCPU or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ide) begin
               state_d = ST_SETUP;
            end else if (start_gayle) begin
               state_d = ST_GWAIT;
            end
         end
         ST_SETUP: begin
            if (AS20) begin
               state_d = ST_HOLD;
            end else if (cnt_zero) begin
               state_d = ST_STROBE;
            end
         end
         ST_STROBE: begin
            if (AS20) begin
               state_d = ST_HOLD;
            end else if (cnt_zero && !stretch) begin
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (AS20) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cnt_zero) begin
               state_d = ST_IDLE;
            end
         end
         ST_GWAIT: begin
            if (AS20) begin
               state_d = ST_IDLE;
            end else if (cnt_zero) begin
               state_d = ST_GACK;
            end
         end
         ST_GACK: begin
            if (AS20) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---- output / counter next values ----
   always_comb begin
      cs0_d   = IDE_CS0_n;
      cs1_d   = IDE_CS1_n;
      ide_a_d = IDE_A;
      ior_d   = IDE_IOR_n;
      iow_d   = IDE_IOW_n;
      bufoe_d = IDE_BUFOE_n;
      dir_d   = IDE_DIR;
      dsack_d = DSACK1_n;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ide) begin
               ide_a_d = A[4:2];
               dir_d   = RW;
               cs0_d   = A[14];
               cs1_d   = ~A[14];
               cnt_d   = SETUP_LD;
            end else if (start_gayle) begin
               cnt_d   = GAYLE_LD;
            end
         end
         ST_SETUP: begin
            if (AS20) begin
               // Abort before the strobe: nothing to negate but CS, after hold.
               cnt_d = HOLD_LD;
            end else if (cnt_zero) begin
               ior_d   = ~IDE_DIR;
               iow_d   = IDE_DIR;
               bufoe_d = 1'b0;
               cnt_d   = STROBE_LD;
               tmo_d   = TMO_LD;
            end else begin
               cnt_d = dec_cnt(cnt_q);
            end
         end
         ST_STROBE: begin
            if (AS20) begin
               // CPU gave up: drop the strobe on this edge, no termination.
               ior_d   = 1'b1;
               iow_d   = 1'b1;
               bufoe_d = 1'b1;
               cnt_d   = HOLD_LD;
            end else if (!cnt_zero) begin
               cnt_d = dec_cnt(cnt_q);
            end else if (stretch) begin
               tmo_d = dec_tmo(tmo_q);
            end else begin
               // Ready, or timeout spent: terminate normally either way.
               dsack_d = 1'b0;
            end
         end
         ST_ACK: begin
            if (AS20) begin
               ior_d   = 1'b1;
               iow_d   = 1'b1;
               bufoe_d = 1'b1;
               dsack_d = 1'b1;
               cnt_d   = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (cnt_zero) begin
               cs0_d = 1'b1;
               cs1_d = 1'b1;
            end else begin
               cnt_d = dec_cnt(cnt_q);
            end
         end
         ST_GWAIT: begin
            if (!AS20) begin
               if (cnt_zero) begin
                  dsack_d = 1'b0;
               end else begin
                  cnt_d = dec_cnt(cnt_q);
               end
            end
         end
         ST_GACK: begin
            if (AS20) begin
               dsack_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ---- registered outputs and counters ----
   always_ff @(posedge CLKCPU or negedge RESET) begin
      if (!RESET) begin
         IDE_CS0_n   <= 1'b1;
         IDE_CS1_n   <= 1'b1;
         IDE_A       <= 3'd0;
         IDE_IOR_n   <= 1'b1;
         IDE_IOW_n   <= 1'b1;
         IDE_BUFOE_n <= 1'b1;
         IDE_DIR     <= 1'b0;
         DSACK1_n    <= 1'b1;
         cnt_q       <= 4'd0;
         tmo_q       <= 8'd0;
      end else begin
         IDE_CS0_n   <= cs0_d;
         IDE_CS1_n   <= cs1_d;
         IDE_A       <= ide_a_d;
         IDE_IOR_n   <= ior_d;
         IDE_IOW_n   <= iow_d;
         IDE_BUFOE_n <= bufoe_d;
         IDE_DIR     <= dir_d;
         DSACK1_n    <= dsack_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
      end
   end

endmodule

// File: tb/tb_ide_cycle.sv
// tb_ide_cycle
//
// Two instances share one stimulus: u_dut0 with default timing and u_dut1
// with a 4-cycle IORDY timeout. A timeline model (edges counted from E0)
// predicts every output of both instances each cycle; directed cycles pin
// the model against hand-computed edge numbers.

module tb_ide_cycle;

   localparam int SETUP  = 2;
   localparam int STROBE = 6;
   localparam int HOLD   = 2;
   localparam int GW     = 1;
   localparam int LIM0   = 255;
   localparam int LIM1   = 4;
   localparam logic [9:0] RST_V = 10'b1100011101;

   logic        CLKCPU;
   logic        RESET;
   logic        AS20;
   logic        RW;
   logic [23:0] A;
   logic        GAYLE_ACCESS;
   logic        IORDY;

   logic       cs0_n [2];
   logic       cs1_n [2];
   logic [2:0] ide_a [2];
   logic       ior_n [2];
   logic       iow_n [2];
   logic       bufoe_n [2];
   logic       dir [2];
   logic       dsack_n [2];
   logic [9:0] ov [2];

   int checks;
   int errors;

   // behavioural model, one copy per instance
   int         m_mode [2];   // 0 idle, 1 ide, 2 gayle
   int         m_t [2];      // edges since E0
   int         m_rel [2];    // edge at which AS20 was seen high, -1 if not yet
   int         m_stalls [2];
   int         m_lim [2];
   logic       m_cs [2];
   logic       m_sel [2];
   logic       m_str [2];
   logic       m_ds [2];
   logic       m_dir [2];
   logic [2:0] m_ia [2];

   ide_cycle #(
      .SETUP_CLKS(SETUP), .STROBE_CLKS(STROBE), .HOLD_CLKS(HOLD),
      .GAYLE_WAIT(GW), .IORDY_TIMEOUT(LIM0)
   ) u_dut0 (
      .CLKCPU(CLKCPU), .RESET(RESET), .AS20(AS20), .RW(RW), .A(A),
      .GAYLE_ACCESS(GAYLE_ACCESS), .IDE_IORDY(IORDY),
      .IDE_CS0_n(cs0_n[0]), .IDE_CS1_n(cs1_n[0]), .IDE_A(ide_a[0]),
      .IDE_IOR_n(ior_n[0]), .IDE_IOW_n(iow_n[0]), .IDE_BUFOE_n(bufoe_n[0]),
      .IDE_DIR(dir[0]), .DSACK1_n(dsack_n[0])
   );

   ide_cycle #(
      .SETUP_CLKS(SETUP), .STROBE_CLKS(STROBE), .HOLD_CLKS(HOLD),
      .GAYLE_WAIT(GW), .IORDY_TIMEOUT(LIM1)
   ) u_dut1 (
      .CLKCPU(CLKCPU), .RESET(RESET), .AS20(AS20), .RW(RW), .A(A),
      .GAYLE_ACCESS(GAYLE_ACCESS), .IDE_IORDY(IORDY),
      .IDE_CS0_n(cs0_n[1]), .IDE_CS1_n(cs1_n[1]), .IDE_A(ide_a[1]),
      .IDE_IOR_n(ior_n[1]), .IDE_IOW_n(iow_n[1]), .IDE_BUFOE_n(bufoe_n[1]),
      .IDE_DIR(dir[1]), .DSACK1_n(dsack_n[1])
   );

   assign ov[0] = {cs0_n[0], cs1_n[0], ide_a[0], ior_n[0], iow_n[0], bufoe_n[0], dir[0], dsack_n[0]};
   assign ov[1] = {cs0_n[1], cs1_n[1], ide_a[1], ior_n[1], iow_n[1], bufoe_n[1], dir[1], dsack_n[1]};

   initial begin
      CLKCPU = 1'b0;
      forever #5 CLKCPU = ~CLKCPU;
   end

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = 0; m_t[i] = 0; m_rel[i] = -1; m_stalls[i] = 0;
         m_cs[i] = 1'b0; m_sel[i] = 1'b0; m_str[i] = 1'b0; m_ds[i] = 1'b0;
         m_dir[i] = 1'b0; m_ia[i] = 3'd0;
      end
      m_lim[0] = LIM0;
      m_lim[1] = LIM1;
   endtask

   task automatic model_step(input int i);
      logic hit;
      hit = (A[23:16] == 8'hDA) && (A[15] == 1'b0);
      if (m_mode[i] == 0) begin
         if (!AS20 && hit) begin
            m_mode[i] = 1; m_t[i] = 0; m_rel[i] = -1; m_stalls[i] = 0;
            m_cs[i] = 1'b1; m_sel[i] = A[14]; m_ia[i] = A[4:2]; m_dir[i] = RW;
         end else if (!AS20 && !GAYLE_ACCESS) begin
            m_mode[i] = 2; m_t[i] = 0;
         end
      end else if (m_mode[i] == 1) begin
         m_t[i]++;
         if (m_rel[i] >= 0) begin
            if (m_t[i] == m_rel[i] + HOLD) begin
               m_cs[i] = 1'b0; m_mode[i] = 0;
            end
         end else if (AS20) begin
            m_rel[i] = m_t[i]; m_str[i] = 1'b0; m_ds[i] = 1'b0;
         end else if (!m_ds[i]) begin
            if (m_t[i] == SETUP) m_str[i] = 1'b1;
            if (m_t[i] >= SETUP + STROBE) begin
               if (IORDY || m_stalls[i] == m_lim[i]) m_ds[i] = 1'b1;
               else m_stalls[i]++;
            end
         end
      end else begin
         m_t[i]++;
         if (m_ds[i]) begin
            if (AS20) begin
               m_ds[i] = 1'b0; m_mode[i] = 0;
            end
         end else if (AS20) begin
            m_mode[i] = 0;
         end else if (m_t[i] == GW) begin
            m_ds[i] = 1'b1;
         end
      end
   endtask

   function automatic logic [9:0] exp_vec(input int i);
      return {!(m_cs[i] && !m_sel[i]), !(m_cs[i] && m_sel[i]), m_ia[i],
              !(m_str[i] && m_dir[i]), !(m_str[i] && !m_dir[i]), !m_str[i],
              m_dir[i], !m_ds[i]};
   endfunction

   task automatic tick();
      @(posedge CLKCPU);
      if (RESET) begin
         model_step(0);
         model_step(1);
      end
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // per-cycle comparison against the model, away from the active edge
   initial begin
      forever begin
         @(negedge CLKCPU);
         for (int i = 0; i < 2; i++) begin
            logic [9:0] e;
            e = exp_vec(i);
            checks++;
            if (ov[i] !== e) begin
               errors++;
               $display("FAIL cycle_dut%0d at %0t got %b expected %b", i, $time, ov[i], e);
            end
         end
      end
   end

   // One IDE cycle, edges numbered from E0. IORDY is low for `stall` edges
   // from E(SETUP+STROBE); AS20 goes high at edge abort_k, or on the edge
   // after DSACK is seen when abort_k < 0.
   task automatic meas(input logic [23:0] addr, input logic rw, input int stall,
                       input int abort_k, input int sel,
                       output int e_str, output int e_ds, output int e_soff,
                       output int e_coff, output logic [9:0] v0, output logic [9:0] vstr);
      int lo;
      logic [9:0] v;
      lo = SETUP + STROBE;
      e_str = -1; e_ds = -1; e_soff = -1; e_coff = -1; v0 = '1; vstr = '1;
      A = addr; RW = rw; GAYLE_ACCESS = 1'b1; AS20 = 1'b0; IORDY = 1'b1;
      for (int k = 0; k < 400 && e_coff < 0; k++) begin
         tick();
         v = ov[sel];
         if (k == 0) v0 = v;
         if (e_str < 0 && !(v[4] && v[3])) begin
            e_str = k; vstr = v;
         end else if (e_str >= 0 && e_soff < 0 && v[4] && v[3]) begin
            e_soff = k;
         end
         if (e_ds < 0 && !v[0]) e_ds = k;
         if (k > 0 && v[9] && v[8]) e_coff = k;
         AS20  = (abort_k >= 0) ? ((k + 1) >= abort_k) : (e_ds >= 0);
         IORDY = !((k + 1) >= lo && (k + 1) < lo + stall);
      end
      AS20 = 1'b1; IORDY = 1'b1;
      tick();
   endtask

   initial begin
      int e_str, e_ds, e_soff, e_coff, dsoff;
      logic [9:0] v0, vstr, v;
      logic touched;
      logic [23:0] ad;
      int r, len;

      checks = 0; errors = 0;
      RESET = 1'b1; AS20 = 1'b1; RW = 1'b1; A = 24'd0; GAYLE_ACCESS = 1'b1; IORDY = 1'b1;
      model_reset();
      #2 RESET = 1'b0;
      tick(); tick();
      chk("reset_vec_dut0", int'(ov[0]), int'(RST_V));
      chk("reset_vec_dut1", int'(ov[1]), int'(RST_V));
      RESET = 1'b1;
      tick();

      // reset asserted in the middle of the strobe
      A = 24'hDA4010; RW = 1'b1; AS20 = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("pre_reset_ior", int'(ov[0][4]), 0);
      #2 RESET = 1'b0;
      #1;
      chk("mid_reset_dut0", int'(ov[0]), int'(RST_V));
      chk("mid_reset_dut1", int'(ov[1]), int'(RST_V));
      model_reset();
      tick(); tick();
      AS20 = 1'b1;
      RESET = 1'b1;
      tick();

      // IDE read at $DA4010
      meas(24'hDA4010, 1'b1, 0, -1, 0, e_str, e_ds, e_soff, e_coff, v0, vstr);
      chk("rd_cs_sel", int'(v0[9:8]), 2);
      chk("rd_ide_a", int'(v0[7:5]), 4);
      chk("rd_dir", int'(v0[1]), 1);
      chk("rd_strobe_edge", e_str, 2);
      chk("rd_ior_not_iow", int'(vstr[4:3]), 1);
      chk("rd_dsack_edge", e_ds, 8);
      chk("rd_strobe_off", e_soff, 9);
      chk("rd_cs_off", e_coff, 11);

      // IDE write at $DA0000, IORDY low for 5 cycles
      meas(24'hDA0000, 1'b0, 5, -1, 0, e_str, e_ds, e_soff, e_coff, v0, vstr);
      chk("wr_cs_sel", int'(v0[9:8]), 1);
      chk("wr_dir", int'(v0[1]), 0);
      chk("wr_iow_not_ior", int'(vstr[4:3]), 2);
      chk("wr_strobe_edge", e_str, 2);
      chk("wr_dsack_edge", e_ds, 13);
      chk("wr_iow_width", e_ds - e_str, 11);
      chk("wr_cs_off", e_coff, 16);

      // IORDY stuck low, 4-cycle timeout instance
      meas(24'hDA0008, 1'b1, 1000, -1, 1, e_str, e_ds, e_soff, e_coff, v0, vstr);
      chk("tmo_dsack_edge", e_ds, 12);
      chk("tmo_cs_off", e_coff, 15);

      // Gayle register read
      A = 24'h123456; GAYLE_ACCESS = 1'b0; RW = 1'b1; AS20 = 1'b0;
      e_ds = -1; dsoff = -1; touched = 1'b0;
      for (int k = 0; k < 40 && dsoff < 0; k++) begin
         tick();
         v = ov[0];
         if (!v[9] || !v[8] || !v[4] || !v[3] || !v[2]) touched = 1'b1;
         if (e_ds < 0 && !v[0]) e_ds = k;
         else if (e_ds >= 0 && v[0]) dsoff = k;
         AS20 = (e_ds >= 0);
      end
      AS20 = 1'b1; GAYLE_ACCESS = 1'b1;
      tick();
      chk("gayle_dsack_edge", e_ds, 1);
      chk("gayle_dsack_off", dsoff, 2);
      chk("gayle_no_ide", int'(touched), 0);

      // abort at E4 of a read
      meas(24'hDA0004, 1'b1, 0, 4, 0, e_str, e_ds, e_soff, e_coff, v0, vstr);
      chk("abort_strobe_edge", e_str, 2);
      chk("abort_strobe_off", e_soff, 4);
      chk("abort_no_dsack", e_ds, -1);
      chk("abort_cs_off", e_coff, 6);

      // next cycle accepted after the abort
      meas(24'hDA4010, 1'b1, 0, -1, 0, e_str, e_ds, e_soff, e_coff, v0, vstr);
      chk("post_abort_cs", int'(v0[9:8]), 2);
      chk("post_abort_dsack", e_ds, 8);

      // randomized traffic, checked every cycle by the model
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         if (r < 55) begin
            ad = {8'hDA, 1'b0, 15'($urandom)};
            GAYLE_ACCESS = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
         end else begin
            ad = 24'($urandom);
            if (ad[23:16] == 8'hDA) ad[23] = 1'b0;
            GAYLE_ACCESS = (r < 85) ? 1'b0 : 1'b1;
         end
         A = ad;
         RW = 1'($urandom);
         AS20 = 1'b0;
         len = $urandom_range(1, 24);
         for (int j = 0; j < len; j++) begin
            IORDY = ($urandom_range(0, 3) != 0);
            tick();
         end
         AS20 = 1'b1;
         len = $urandom_range(0, 4);
         for (int j = 0; j < len; j++) begin
            IORDY = 1'($urandom);
            tick();
         end
      end
      AS20 = 1'b1; GAYLE_ACCESS = 1'b1; IORDY = 1'b1;
      for (int j = 0; j < 20; j++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ide_cycle.md
# ide_cycle

Bus-cycle controller that sits directly downstream of the gayle register block. It consumes gayle's active-low `ACCESS` decode and the raw 68030 bus strobes. For Gayle register cycles it generates the `DSACK` termination. For the IDE window at $DA0000–$DA7FFF it runs a timed PIO cycle: `CS` setup, `IOR`/`IOW` strobe with `IORDY` stretching, `CS` hold. It drives the IDE chip selects, register address, strobes and data-buffer controls.

## Interface
Parameters:
- `SETUP_CLKS`, 2, CLKCPU cycles from `CS` assert to strobe assert (legal range 1..15)
- `STROBE_CLKS`, 6, minimum strobe width in CLKCPU cycles (1..15)
- `HOLD_CLKS`, 2, CLKCPU cycles `CS` stays asserted after strobe negate (1..15)
- `GAYLE_WAIT`, 1, CLKCPU cycles before `DSACK` on a Gayle register cycle (1..15)
- `IORDY_TIMEOUT`, 255, maximum CLKCPU cycles of `IORDY` stretch (1..255)

Ports:
- `CLKCPU` in 1 — CPU clock; all state changes on the rising edge
- `RESET` in 1 — asynchronous, active-low reset
- `AS20` in 1 — 68030 address strobe, active-low, synchronous to `CLKCPU`
- `RW` in 1 — 1 = read, 0 = write
- `A` in 24 — CPU address `[23:0]`
- `GAYLE_ACCESS` in 1 — active-low Gayle register decode from the gayle block
- `IDE_IORDY` in 1 — drive ready; 0 = stretch the strobe
- `IDE_CS0_n`, `IDE_CS1_n` out 1 each — IDE chip selects
- `IDE_A` out 3 — IDE register address
- `IDE_IOR_n`, `IDE_IOW_n` out 1 each — IDE strobes
- `IDE_BUFOE_n` out 1 — data buffer output enable
- `IDE_DIR` out 1 — buffer direction; 1 = drive toward CPU
- `DSACK1_n` out 1 — 16-bit port termination to the CPU

## Operation
- **Decode**
  - IDE hit when `A[23:15]` == {8'hDA, 1'b0}.
  - `A[14]` = 0 selects `CS0`; `A[14]` = 1 selects `CS1`.
  - `IDE_A` = `A[4:2]`.
  - Gayle hit when `GAYLE_ACCESS` = 0.
  - The two hits are mutually exclusive. If both are active, IDE wins.
- **State machine:** IDLE, SETUP, STROBE, ACK, HOLD, GWAIT, GACK. All outputs are registered.
- **IDLE**
  - If `AS20` = 0 and IDE hit:
    - latch `IDE_A`, chip select and `IDE_DIR` = `RW`;
    - assert the selected `CS`;
    - load `cnt` = `SETUP_CLKS`-1;
    - go to SETUP.
  - Else if `AS20` = 0 and Gayle hit: load `cnt` = `GAYLE_WAIT`-1; go to GWAIT.
- **SETUP**
  - Decrement `cnt`.
  - When `cnt` = 0:
    - assert `IDE_IOR_n` (read) or `IDE_IOW_n` (write);
    - assert `IDE_BUFOE_n`;
    - load `cnt` = `STROBE_CLKS`-1 and `tmo` = `IORDY_TIMEOUT`;
    - go to STROBE.
- **STROBE**
  - Decrement `cnt`.
  - At `cnt` = 0, stay while `IDE_IORDY` = 0 and `tmo` != 0; `tmo` decrements each such cycle.
  - Otherwise assert `DSACK1_n` and go to ACK.
- **ACK**
  - Strobe, `IDE_BUFOE_n` and `DSACK1_n` stay asserted until `AS20` is sampled 1.
  - Then negate all three, load `cnt` = `HOLD_CLKS`-1, and go to HOLD.
- **HOLD:** decrement `cnt`; at 0, negate `CS` and go to IDLE. A new `AS20` assertion waits in IDLE decode.
- **GWAIT → GACK:** at `cnt` = 0, assert `DSACK1_n`. In GACK, negate `DSACK1_n` when `AS20` is sampled 1, then go to IDLE.
- **Abort:** `AS20` sampled 1 in SETUP or STROBE:
  - negate strobe and `IDE_BUFOE_n` immediately (same edge);
  - never assert `DSACK1_n`;
  - go to HOLD.
  - In GWAIT, the same condition returns to IDLE.
- **Timeout:** if `tmo` reaches 0, terminate normally. No bus error is signalled.
- **Reset** (any state, asynchronous):
  - state = IDLE;
  - `CS0_n`, `CS1_n`, `IOR_n`, `IOW_n`, `BUFOE_n`, `DSACK1_n` = 1;
  - `IDE_A` = 0; `IDE_DIR` = 0; counters = 0.
- **Width rules:**
  - `cnt` is 4 bits; `tmo` is 8 bits.
  - Counters never wrap: a counter at 0 does not decrement further.

## Timing
- Edges are numbered from E0, the edge that first samples `AS20` = 0 with an IDE hit.
- `CS` asserts at E0.
- Strobe asserts at E(`SETUP_CLKS`).
- With `IORDY` = 1, `DSACK1_n` asserts at E(`SETUP_CLKS`+`STROBE_CLKS`).
- With defaults: `CS` @E0, strobe @E2, `DSACK` @E8.
- Strobe and `DSACK` negate on the first edge sampling `AS20` = 1 in ACK; `CS` negates `HOLD_CLKS` edges later.
- Each `IORDY`-low cycle at `cnt` = 0 adds exactly one cycle to the strobe.
- Gayle cycle: `DSACK1_n` asserts at E(`GAYLE_WAIT`); with default 1, at E1.
- Minimum IDE back-to-back spacing: `HOLD_CLKS` + 1 edges from `AS20` negate to the next `CS` assert.

## Test plan
- **Reset values:** assert `RESET` = 0 mid-STROBE → all strobes, `CS` and `DSACK1_n` = 1 immediately; state IDLE after release.
- **IDE read at $DA4010, defaults, `IORDY` = 1:**
  - `CS1_n` low @E0 with `IDE_A` = 3'b100, `IDE_DIR` = 1;
  - `IOR_n` low @E2; `DSACK1_n` low @E8;
  - `AS20` negate → `IOR_n`/`DSACK1_n` high next edge; `CS1_n` high 2 edges later.
- **IDE write at $DA0000 with `IORDY` held 0 for 5 cycles:** `IOW_n` width = 11 cycles; `DSACK1_n` @E13; `CS0_n` asserted, `IDE_DIR` = 0.
- **`IORDY` stuck 0 with `IORDY_TIMEOUT` = 4:** `DSACK1_n` asserts @E12 (defaults) and the cycle completes.
- **Gayle read with `GAYLE_ACCESS` = 0:** `DSACK1_n` low @E1; no IDE strobe or `CS` ever asserts; `DSACK1_n` high one edge after `AS20` = 1.
- **Abort:** `AS20` negated at E4 of an IDE read → `IOR_n` high at E4; `DSACK1_n` never asserts; `CS` high at E6; next cycle accepted from IDLE.
